// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between CPU bus writes and
// the hardware RX-echo path. Each source has its own FIFO. An arbiter picks
// the next byte, and a small FSM then runs the UART start/busy handshake.
//
// Build option: define UART_TX_SCHED_RR_EN to replace fixed CPU priority with
// round-robin arbitration between the two sources.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   cpu_wr_en/_data   CPU byte push; cpu_full = CPU FIFO full
//   echo_valid/_data  echo byte offer; echo_ready = echo FIFO not full
//   err_clr           clears the sticky cpu_ovf / tx_timeout flags
//   tx_status         UART idle (1) / busy (0)
//   tx_data/tx_start  byte and one-cycle start strobe to the UART
//   busy              scheduler not in IDLE
//   grant_src         source of the current/last byte (0 = CPU, 1 = echo)
//   cpu_ovf           sticky: a CPU write was dropped because the FIFO was full
//   tx_timeout        sticky: the UART did not acknowledge a start pulse

// Single-clock byte FIFO. Full/empty are registered, so the push check always
// uses the count from before the current cycle's pop.
module uart_tx_sched_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_head,
   output logic       o_empty,
   output logic       o_full
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_empty;
   logic          r_full;
   logic [CW-1:0] w_count_nxt;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign w_push_ok = i_push && !r_full;
   assign w_pop_ok  = i_pop && !r_empty;

   // Next occupancy; push and pop together leave it unchanged.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push_ok && !w_pop_ok) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == CW'(0));
         r_full  <= (w_count_nxt == CW'(DEPTH));
      end
   end

   // Storage needs no reset; the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = r_empty;
   assign o_full  = r_full;
endmodule

module uart_tx_scheduler #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_wr_en,
   input  logic [7:0] cpu_wr_data,
   output logic       cpu_full,
   input  logic       echo_valid,
   input  logic [7:0] echo_data,
   output logic       echo_ready,
   input  logic       err_clr,
   input  logic       tx_status,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       busy,
   output logic       grant_src,
   output logic       cpu_ovf,
   output logic       tx_timeout
);
   localparam int unsigned TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_ACK  = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]    r_state;
   logic [TW-1:0] r_cnt;
   logic [7:0]    r_tx_data;
   logic          r_tx_start;
   logic          r_busy;
   logic          r_grant_src;
   logic          r_cpu_ovf;
   logic          r_tx_timeout;

   logic [1:0]    w_state_nxt;
   logic [TW-1:0] w_cnt_nxt;
   logic          w_cpu_pop;
   logic          w_echo_pop;
   logic          w_timeout_set;
   logic          w_pick_echo;
   logic [7:0]    w_cpu_head;
   logic [7:0]    w_echo_head;
   logic          w_cpu_empty;
   logic          w_cpu_full;
   logic          w_echo_empty;
   logic          w_echo_full;
   logic          w_echo_push;

   assign w_echo_push = echo_valid && !w_echo_full;

   uart_tx_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_cpu_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (cpu_wr_en),
      .i_data  (cpu_wr_data),
      .i_pop   (w_cpu_pop),
      .o_head  (w_cpu_head),
      .o_empty (w_cpu_empty),
      .o_full  (w_cpu_full)
   );

   uart_tx_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_echo_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_echo_push),
      .i_data  (echo_data),
      .i_pop   (w_echo_pop),
      .o_head  (w_echo_head),
      .o_empty (w_echo_empty),
      .o_full  (w_echo_full)
   );

   // Source select; only consulted when at least one FIFO holds data.
`ifdef UART_TX_SCHED_RR_EN
   logic r_last_echo;

   assign w_pick_echo = !w_echo_empty && (w_cpu_empty || !r_last_echo);

   // Last-grant memory starts at echo so the first contested grant is CPU.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_echo <= 1'b1;
      end else if (w_cpu_pop || w_echo_pop) begin
         r_last_echo <= w_echo_pop;
      end
   end
`else
   assign w_pick_echo = w_cpu_empty;
`endif

   // Next-state, FIFO pop and ack-timeout logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_cpu_pop     = 1'b0;
      w_echo_pop    = 1'b0;
      w_timeout_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tx_status && (!w_cpu_empty || !w_echo_empty)) begin
               w_cpu_pop   = !w_pick_echo;
               w_echo_pop  = w_pick_echo;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (!tx_status) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_cnt == TW'(ACK_TIMEOUT - 1)) begin
               // UART never went busy: drop the byte and carry on.
               w_timeout_set = 1'b1;
               w_state_nxt   = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (tx_status) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; sticky flags give set priority over clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_tx_data    <= '0;
         r_tx_start   <= 1'b0;
         r_busy       <= 1'b0;
         r_grant_src  <= 1'b0;
         r_cpu_ovf    <= 1'b0;
         r_tx_timeout <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_tx_start <= (w_state_nxt == S_ISSUE);
         r_busy     <= (w_state_nxt != S_IDLE);
         if (w_cpu_pop || w_echo_pop) begin
            r_tx_data   <= w_echo_pop ? w_echo_head : w_cpu_head;
            r_grant_src <= w_echo_pop;
         end
         if (cpu_wr_en && w_cpu_full) begin
            r_cpu_ovf <= 1'b1;
         end else if (err_clr) begin
            r_cpu_ovf <= 1'b0;
         end
         if (w_timeout_set) begin
            r_tx_timeout <= 1'b1;
         end else if (err_clr) begin
            r_tx_timeout <= 1'b0;
         end
      end
   end

   assign cpu_full   = w_cpu_full;
   assign echo_ready = !w_echo_full;
   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;
   assign busy       = r_busy;
   assign grant_src  = r_grant_src;
   assign cpu_ovf    = r_cpu_ovf;
   assign tx_timeout = r_tx_timeout;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler (FIFO_DEPTH=4, ACK_TIMEOUT=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_scheduler;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cpu_wr_en = 1'b0;
   logic [7:0] cpu_wr_data = 8'h00;
   logic       cpu_full;
   logic       echo_valid = 1'b0;
   logic [7:0] echo_data = 8'h00;
   logic       echo_ready;
   logic       err_clr = 1'b0;
   logic       tx_status = 1'b1;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic       grant_src;
   logic       cpu_ovf;
   logic       tx_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_scheduler #(.FIFO_DEPTH(4), .ACK_TIMEOUT(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_wr_en   (cpu_wr_en),
      .cpu_wr_data (cpu_wr_data),
      .cpu_full    (cpu_full),
      .echo_valid  (echo_valid),
      .echo_data   (echo_data),
      .echo_ready  (echo_ready),
      .err_clr     (err_clr),
      .tx_status   (tx_status),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .busy        (busy),
      .grant_src   (grant_src),
      .cpu_ovf     (cpu_ovf),
      .tx_timeout  (tx_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests incomplete");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      reset      = 1'b0;
      cpu_wr_en  = 1'b0;
      echo_valid = 1'b0;
      err_clr    = 1'b0;
      tx_status  = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Emulated UART: wait (bounded) for a start strobe, then go busy for two
   // cycles and return to idle. Reports the byte and grant seen at the strobe.
   task automatic serve_byte(output bit ok, output logic [7:0] d, output logic g);
      ok = 1'b0;
      d  = 8'h00;
      g  = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            ok = 1'b1;
            d  = tx_data;
            g  = grant_src;
         end
      end
      if (ok) begin
         @(negedge clk);
         tx_status = 1'b0;
         @(negedge clk);
         @(negedge clk);
         tx_status = 1'b1;
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (grant_src !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant_src); end
      n_checks++; if (cpu_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ovf: got %b want 0", cpu_ovf); end
      n_checks++; if (tx_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", tx_timeout); end
      n_checks++; if (cpu_full !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_full: got %b want 0", cpu_full); end
      n_checks++; if (echo_ready !== 1'b1) begin n_fail++; $display("FAIL reset_echo_ready: got %b want 1", echo_ready); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      cpu_wr_en = 1'b1; cpu_wr_data = 8'h41;
      @(negedge clk);
      cpu_wr_en = 1'b0;
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %b want 0", tx_start); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_early_busy: got %b want 0", busy); end
      @(negedge clk);
      n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", tx_start); end
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", tx_data); end
      n_checks++; if (grant_src !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %b want 0", grant_src); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
      tx_status = 1'b0;
      @(negedge clk);
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b want 0", tx_start); end
      repeat (9) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_held: got %b want 1", busy); end
      tx_status = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy); end
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data_hold: got %h want 41", tx_data); end
   endtask

   task automatic test_overflow();
      bit         ok;
      logic [7:0] d;
      logic       g;
      int         starts;
      do_reset();
      tx_status = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 4) begin
            n_checks++; if (cpu_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_at4: got %b want 1", cpu_full); end
            n_checks++; if (cpu_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %b want 0", cpu_ovf); end
         end
         cpu_wr_en = 1'b1; cpu_wr_data = 8'h10 + 8'(i);
      end
      @(negedge clk);
      cpu_wr_en = 1'b0;
      n_checks++; if (cpu_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", cpu_full); end
      n_checks++; if (cpu_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", cpu_ovf); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy: got %b want 0", busy); end
      // Clear and a fresh overflow in the same cycle: set must win.
      err_clr = 1'b1; cpu_wr_en = 1'b1; cpu_wr_data = 8'h15;
      @(negedge clk);
      cpu_wr_en = 1'b0;
      n_checks++; if (cpu_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", cpu_ovf); end
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++; if (cpu_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", cpu_ovf); end
      tx_status = 1'b1;
      for (int i = 0; i < 4; i++) begin
         serve_byte(ok, d, g);
         n_checks++; if (!ok || d !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h started=%0b want %h", i, d, ok, 8'h10 + 8'(i)); end
         n_checks++; if (g !== 1'b0) begin n_fail++; $display("FAIL ovf_grant[%0d]: got %b want 0", i, g); end
      end
      n_checks++; if (cpu_full !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_full: got %b want 0", cpu_full); end
      starts = 0;
      repeat (12) begin
         @(negedge clk);
         if (tx_start === 1'b1) starts++;
      end
      n_checks++; if (starts != 0) begin n_fail++; $display("FAIL ovf_dropped_sent: got %0d extra starts want 0", starts); end
   endtask

   task automatic test_arbitration();
      bit         ok;
      logic [7:0] d;
      logic       g;
      logic [7:0] exp_d [4];
      logic       exp_g [4];
`ifdef UART_TX_SCHED_RR_EN
      exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
      exp_g = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
      do_reset();
      tx_status = 1'b0;
      @(negedge clk);
      cpu_wr_en = 1'b1; cpu_wr_data = 8'hA0; echo_valid = 1'b1; echo_data = 8'hB0;
      @(negedge clk);
      cpu_wr_data = 8'hA1; echo_data = 8'hB1;
      @(negedge clk);
      cpu_wr_en = 1'b0; echo_valid = 1'b0;
      tx_status = 1'b1;
      for (int i = 0; i < 4; i++) begin
         serve_byte(ok, d, g);
         n_checks++; if (!ok || d !== exp_d[i]) begin n_fail++; $display("FAIL arb_order[%0d]: got %h started=%0b want %h", i, d, ok, exp_d[i]); end
         n_checks++; if (g !== exp_g[i]) begin n_fail++; $display("FAIL arb_grant[%0d]: got %b want %b", i, g, exp_g[i]); end
      end
   endtask

   task automatic test_timeout();
      bit         ok;
      logic [7:0] d;
      logic       g;
      do_reset();
      @(negedge clk);
      cpu_wr_en = 1'b1; cpu_wr_data = 8'h55;
      @(negedge clk);
      cpu_wr_data = 8'h66;
      @(negedge clk);
      cpu_wr_en = 1'b0;
      n_checks++; if (tx_start !== 1'b1 || tx_data !== 8'h55) begin n_fail++; $display("FAIL to_first_start: got start=%b data=%h want start=1 data=55", tx_start, tx_data); end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 16) begin
            n_checks++; if (tx_timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_early: got timeout=%b busy=%b want 0/1", tx_timeout, busy); end
         end
      end
      @(negedge clk);
      n_checks++; if (tx_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", tx_timeout); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got busy=%b want 0", busy); end
      serve_byte(ok, d, g);
      n_checks++; if (!ok || d !== 8'h66) begin n_fail++; $display("FAIL to_next_byte: got %h started=%0b want 66", d, ok); end
      n_checks++; if (tx_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", tx_timeout); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++; if (tx_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", tx_timeout); end
   endtask

   task automatic test_reset_mid();
      int starts;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_wr_en = 1'b1; cpu_wr_data = 8'h70 + 8'(i);
      end
      @(negedge clk);
      cpu_wr_en = 1'b0;
      tx_status = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_async_fsm: got busy=%b start=%b want 0/0", busy, tx_start); end
      n_checks++; if (tx_data !== 8'h00 || grant_src !== 1'b0) begin n_fail++; $display("FAIL mid_async_data: got data=%h grant=%b want 00/0", tx_data, grant_src); end
      n_checks++; if (cpu_full !== 1'b0 || echo_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_fifo: got full=%b ready=%b want 0/1", cpu_full, echo_ready); end
      n_checks++; if (cpu_ovf !== 1'b0 || tx_timeout !== 1'b0) begin n_fail++; $display("FAIL mid_async_flags: got ovf=%b to=%b want 0/0", cpu_ovf, tx_timeout); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      tx_status = 1'b1;
      starts = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_start === 1'b1) starts++;
      end
      n_checks++; if (starts != 0) begin n_fail++; $display("FAIL mid_no_start: got %0d starts want 0", starts); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_after: got busy=%b want 0", busy); end
   endtask

   task automatic test_wrap();
      bit         ok;
      logic [7:0] d;
      logic       g;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         n_checks++; if (echo_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b want 1", i, echo_ready); end
         echo_valid = 1'b1; echo_data = 8'hC0 + 8'(i);
         @(negedge clk);
         echo_valid = 1'b0;
         serve_byte(ok, d, g);
         n_checks++; if (!ok || d !== 8'hC0 + 8'(i)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h started=%0b want %h", i, d, ok, 8'hC0 + 8'(i)); end
         n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL wrap_grant[%0d]: got %b want 1", i, g); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_arbitration();
      test_timeout();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
